// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding, the default
// frame header and the smallest legal SCK half-period in clk cycles.
// Pure declarations; no logic, no latency, no flow control.
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // Expected first 32 received bits when header checking is compiled in.
    localparam logic [31:0] SPI_HEADER_DEFAULT = 32'h74697277;

    // The FPGA-side slave edge-detects SCK through synchronisers, so each
    // SCK level must last at least this many clk cycles.
    localparam int SPI_CLK_DIV_MIN = 4;

endpackage

// File: rtl/spi_clk_tick.sv
// SCK half-period timer: down-counter reloaded with CLK_DIV-1, tick while it reads zero.
// Latency: first tick CLK_DIV cycles after restart is released, then every CLK_DIV cycles.
// No backpressure; restart holds the counter at its reload value.
// Ports: clk, reset (sync, active high), restart (hold/reload), tick (one-cycle pulse).
module spi_clk_tick
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    if (CLK_DIV < SPI_CLK_DIV_MIN) begin : g_bad_div
        $error("spi_clk_tick: CLK_DIV below minimum supported by the slave");
    end

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one BUFFER_SIZE-bit frame per accepted start, MSB first, MISO captured on SCK rise.
// Latency: done pulses CLK_DIV*(2*BUFFER_SIZE+2)+GAP_CYCLES+1 cycles after the accept edge.
// Backpressure: start is only accepted while busy==0; starts during a frame are dropped, not queued.
// Ports: clk, reset (sync, active high), start, tx_data -> busy, done, rx_data, hdr_err;
//        SPI_SCK/SPI_SSEL/SPI_MOSI out, SPI_MISO in.
// Build option: define SPI_RX_HEADER_CHECK_EN to gate rx_data updates on a matching 32-bit header.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int BUFFER_SIZE = 64,
    parameter int CLK_DIV     = 4,
    parameter int GAP_CYCLES  = 8
`ifdef SPI_RX_HEADER_CHECK_EN
    ,
    parameter logic [31:0] HEADER = SPI_HEADER_DEFAULT
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   hdr_err,
    output logic                   SPI_SCK,
    output logic                   SPI_SSEL,
    output logic                   SPI_MOSI,
    input  logic                   SPI_MISO
);

`ifdef SPI_RX_HEADER_CHECK_EN
    if (BUFFER_SIZE < 33) begin : g_bad_size
        $error("spi_master: header check needs BUFFER_SIZE >= 33");
    end
`endif

    localparam int BCW = $clog2(BUFFER_SIZE + 1);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    spi_state_t             state;
    logic [BUFFER_SIZE-1:0] tx_sh;
    logic [BUFFER_SIZE-1:0] rx_sh;
    logic [BCW-1:0]         bit_cnt;   // SCK falls completed in this frame
    logic [GCW-1:0]         gap_cnt;
    logic                   tick;

    // The timer is held in reload while idle, so the accept edge starts a fresh
    // half-period. Every later state change happens on a tick, where the counter
    // reloads by itself, so no explicit restart is needed there.
    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (state == ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            SPI_SCK  <= 1'b0;
            SPI_SSEL <= 1'b1;
            SPI_MOSI <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hdr_err  <= 1'b0;
            rx_data  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            hdr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // busy is still high in the done cycle, which blocks a start there.
                    if (start && !busy) begin
                        tx_sh    <= tx_data;
                        SPI_MOSI <= tx_data[BUFFER_SIZE-1];
                        SPI_SSEL <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= ST_SETUP;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        SPI_SCK <= 1'b1;
                        rx_sh   <= {rx_sh[BUFFER_SIZE-2:0], SPI_MISO};
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (SPI_SCK) begin
                            SPI_SCK  <= 1'b0;
                            tx_sh    <= tx_sh << 1;
                            SPI_MOSI <= tx_sh[BUFFER_SIZE-2];
                            bit_cnt  <= bit_cnt + BCW'(1);
                        end else if (bit_cnt == BCW'(BUFFER_SIZE)) begin
                            // Final low half-period is complete; no further rise.
                            state <= ST_HOLD;
                        end else begin
                            SPI_SCK <= 1'b1;
                            rx_sh   <= {rx_sh[BUFFER_SIZE-2:0], SPI_MISO};
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        SPI_SSEL <= 1'b1;
                        SPI_MOSI <= 1'b0;
                        gap_cnt  <= GCW'(GAP_CYCLES);
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
`ifdef SPI_RX_HEADER_CHECK_EN
                        if (rx_sh[BUFFER_SIZE-1 -: 32] == HEADER) begin
                            rx_data <= rx_sh;
                        end else begin
                            hdr_err <= 1'b1;
                        end
`else
                        rx_data <= rx_sh;
`endif
                    end else begin
                        gap_cnt <= gap_cnt - GCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
